stream_output_buffer: RTL and testbench
=======================================

STREAM_OUTPUT_BUFFER -- requirements
Module: stream_output_buffer

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter DEPTH, default 8, buffer entries; SHALL be a power of two and at least 2.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 async_rst_n  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous active-high clear.
REQ-006 data_in  input  WIDTH  upstream word, no backpressure path.
REQ-007 valid_in  input  1  data_in is valid this cycle.
REQ-008 data_out  output  WIDTH  head-of-buffer word.
REQ-009 valid_out  output  1  data_out is valid.
REQ-010 ready_in  input  1  downstream accepts data_out this cycle.
REQ-011 full  output  1  level equals DEPTH.
REQ-012 empty  output  1  level equals 0.
REQ-013 level  output  $clog2(DEPTH)+1  current entry count.
REQ-014 overflow  output  1  sticky flag: a valid input word was dropped.
REQ-015 drop_count  output  16  dropped-word count; present only with STREAM_BUF_DROP_CNT_EN.

Function
REQ-016 The block SHALL be a first-word-fall-through FIFO. It takes the valid-qualified stream from the pipeline directly upstream and adds a ready/valid handshake toward the consumer.
REQ-017 Pop SHALL occur when valid_out && ready_in.
REQ-018 Push SHALL occur when valid_in && (!full || pop) && !flush.
REQ-019 A word pushed into an empty buffer at edge N SHALL appear on data_out with valid_out=1 after edge N, giving one-cycle latency.
REQ-020 valid_out SHALL equal !empty; data_out SHALL be '0 whenever empty=1.
REQ-021 Simultaneous push and pop SHALL leave level unchanged. This holds when full, and the new word is stored.
REQ-022 Simultaneous push and pop when empty SHALL be impossible, because valid_out=0.
REQ-023 valid_in=1 while full=1 and no pop SHALL drop the word: no buffer state changes, and overflow is set at the next edge.
REQ-024 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH with no bubble.
REQ-025 level SHALL be registered; full and empty SHALL be derived combinationally from level.
REQ-026 Ordering SHALL be strict FIFO; no word is duplicated or reordered.
REQ-027 flush=1 at an edge SHALL clear pointers, level, overflow and drop_count, and ignore valid_in and ready_in that cycle. Buffer RAM contents need not clear.
REQ-028 overflow SHALL stay 1 until flush or reset.

Reset
REQ-029 async_rst_n=0 SHALL immediately force pointers=0, level=0, overflow=0 and drop_count=0.
REQ-030 During reset, outputs SHALL be data_out='0, valid_out=0, empty=1, full=0.
REQ-031 Reset asserted mid-transfer SHALL discard all buffered words. After release, the first accepted word SHALL be the first valid_in word sampled at a clock edge with async_rst_n=1.
REQ-032 Storage RAM SHALL have no reset requirement.

Configuration
REQ-033 Macro STREAM_BUF_DROP_CNT_EN defined: drop_count port and logic SHALL exist. It increments by 1 per dropped word, saturates at 16'hFFFF, and clears on flush and reset.
REQ-034 Macro STREAM_BUF_DROP_CNT_EN undefined: the drop_count port and counter SHALL be absent. All other behaviour is unchanged.

Verification
REQ-035 Reset release, then push 0x0001 with ready_in=0 -> next cycle valid_out=1, data_out=0x0001, level=1.
REQ-036 DEPTH=8, push 0x0010..0x0019 (10 words) with ready_in=0 -> full=1, level=8, overflow=1, drop_count=2. Then ready_in=1 -> reads 0x0010..0x0017 in order.
REQ-037 Full buffer, valid_in=1 and ready_in=1 every cycle for 20 cycles -> level stays 8, no drops, output sequence continuous across pointer wrap.
REQ-038 Level 5 with overflow=1, assert flush with valid_in=1 -> next cycle level=0, empty=1, overflow=0, drop_count=0, flushed-cycle word not stored.
REQ-039 Level 3, assert async_rst_n=0 between edges -> valid_out=0 and level=0 without waiting for a clock edge. After release, push 0x00AA -> 0x00AA is the first word read.
REQ-040 Macro defined, 70000 drops while full -> drop_count=0xFFFF and holds there.

Source files
------------

// File: rtl/stream_output_buffer.sv
`default_nettype none
// ============================================================================
// Module      : stream_output_buffer
// Description : First-word-fall-through FIFO adding a ready/valid handshake to
//               a backpressure-free upstream stream. Optional dropped-word
//               counter enabled by macro STREAM_BUF_DROP_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_output_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       async_rst_n,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       valid_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       valid_out,
  input  logic                       ready_in,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
`ifdef STREAM_BUF_DROP_CNT_EN
  ,
  output logic [15:0]                drop_count
`endif
);

  localparam int c_ADDR_W = $clog2(DEPTH);
  localparam int c_LVL_W  = c_ADDR_W + 1;
  localparam logic [c_LVL_W-1:0] c_FULL_LVL = c_LVL_W'(DEPTH);

  logic [WIDTH-1:0]    r_mem [0:DEPTH-1];
  logic [c_ADDR_W-1:0] r_wr_ptr;
  logic [c_ADDR_W-1:0] r_rd_ptr;
  logic [c_LVL_W-1:0]  r_level;
  logic                r_overflow;

  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  logic [c_LVL_W-1:0]  w_level_nxt;

  assign w_full  = (r_level == c_FULL_LVL);
  assign w_empty = (r_level == '0);

  // Flush masks both handshakes so the flushed cycle never moves data.
  assign w_pop  = !w_empty && ready_in && !flush;
  assign w_push = valid_in && (!w_full || w_pop) && !flush;
  assign w_drop = valid_in && w_full && !w_pop && !flush;

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + 1'b1;
    end else if (w_pop && !w_push) begin
      w_level_nxt = r_level - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_level <= w_level_nxt;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage carries no reset; only pointer-qualified entries are ever read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

`ifdef STREAM_BUF_DROP_CNT_EN
  logic [15:0] r_drop_count;

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_drop_count <= '0;
    end else if (flush) begin
      r_drop_count <= '0;
    end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
      r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign drop_count = r_drop_count;
`endif

  assign full      = w_full;
  assign empty     = w_empty;
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign valid_out = !w_empty;
  assign data_out  = w_empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_stream_output_buffer.sv
`default_nettype none
// Self-checking bench for stream_output_buffer: directed scenarios plus random
// traffic, compared against a queue-based reference model.
module tb_stream_output_buffer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             async_rst_n = 1'b0;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             valid_in = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             ready_in = 1'b0;
  logic             full;
  logic             empty;
  logic [LW-1:0]    level;
  logic             overflow;
`ifdef STREAM_BUF_DROP_CNT_EN
  logic [15:0]      drop_count;
`endif

  stream_output_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .async_rst_n(async_rst_n),
    .flush      (flush),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .overflow   (overflow)
`ifdef STREAM_BUF_DROP_CNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [WIDTH-1:0] mq[$];
  logic             m_ovf = 1'b0;
  int               m_drops = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".level"}, 32'(level), 32'(mq.size()));
    chk({tag, ".valid_out"}, 32'(valid_out), 32'(mq.size() != 0));
    chk({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
    chk({tag, ".full"}, 32'(full), 32'(mq.size() == DEPTH));
    chk({tag, ".data_out"}, 32'(data_out), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
`ifdef STREAM_BUF_DROP_CNT_EN
    chk({tag, ".drop_count"}, 32'(drop_count), 32'(m_drops));
`endif
  endtask

  // One clock cycle: inputs applied at negedge, model updated from the
  // handshake rules, outputs compared 1 time unit after the rising edge.
  task automatic cycle(input logic vin, input logic [WIDTH-1:0] din,
                       input logic rdy, input logic fl, input string tag,
                       input bit do_check = 1'b1);
    bit m_pop, m_push, m_drop, m_full;
    @(negedge clk);
    valid_in = vin;
    data_in  = din;
    ready_in = rdy;
    flush    = fl;
    m_full = (mq.size() == DEPTH);
    m_pop  = (mq.size() != 0) && rdy && !fl;
    m_push = vin && (!m_full || m_pop) && !fl;
    m_drop = vin && m_full && !m_pop && !fl;
    @(posedge clk);
    #1;
    if (fl) begin
      mq.delete();
      m_ovf = 1'b0;
      m_drops = 0;
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(din);
      if (m_drop) begin
        m_ovf = 1'b1;
        if (m_drops < 65535) m_drops++;
      end
    end
    if (do_check) check_all(tag);
  endtask

  initial begin
    // Reset state held across edges
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    async_rst_n = 1'b1;

    // Single push, one-cycle latency
    cycle(1'b1, 16'h0001, 1'b0, 1'b0, "push1");
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, "drain1");

    // Overfill: 10 words into 8 entries, then read back in order
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 16'h0010 + 16'(i), 1'b0, 1'b0, "overfill");
    for (int i = 0; i < 8; i++)
      cycle(1'b0, 16'h0000, 1'b1, 1'b0, "readback");

    // Refill, then concurrent push/pop while full across pointer wrap
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0, "refill");
    for (int i = 0; i < 20; i++)
      cycle(1'b1, 16'($urandom), 1'b1, 1'b0, "fullstream");

    // Down to level 5 (overflow still sticky), then flush with valid_in high
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 16'h0000, 1'b1, 1'b0, "to_lvl5");
    chk("lvl5.level", 32'(level), 32'd5);
    chk("lvl5.overflow", 32'(overflow), 32'd1);
    cycle(1'b1, 16'hDEAD, 1'b1, 1'b1, "flush");
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, "postflush");

    // Random traffic
    for (int i = 0; i < 400; i++)
      cycle(1'(($urandom_range(0, 3)) != 0), 16'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 59) == 0), "random");

    // Asynchronous reset mid-cycle with three words buffered
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, "preflush");
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 16'h0050 + 16'(i), 1'b0, 1'b0, "lvl3");
    @(negedge clk);
    valid_in = 1'b0;
    ready_in = 1'b0;
    @(posedge clk);
    #2;
    async_rst_n = 1'b0;
    #1;
    mq.delete();
    m_ovf = 1'b0;
    m_drops = 0;
    check_all("async_rst");
    @(negedge clk);
    async_rst_n = 1'b1;
    cycle(1'b1, 16'h00AA, 1'b0, 1'b0, "post_rst_push");
    chk("post_rst.first_word", 32'(data_out), 32'h00AA);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, "post_rst_drain");

`ifdef STREAM_BUF_DROP_CNT_EN
    // Drop counter saturation
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 16'(i), 1'b0, 1'b0, "sat_fill");
    for (int i = 0; i < 70000; i++)
      cycle(1'b1, 16'(i), 1'b0, 1'b0, "sat_drop", 1'b0);
    check_all("sat");
    chk("sat.drop_count", 32'(drop_count), 32'h0000FFFF);
    cycle(1'b1, 16'h1234, 1'b0, 1'b0, "sat_hold");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
